// File: rtl/fastdiv_seq.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, busy/valid handshake.
// Define FASTDIV_SIGNED_EN to build the two's-complement variant.
module fastdiv_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enbl,
  input  logic [WIDTH-1:0]     xin,
  input  logic [WIDTH-1:0]     yin,
  output logic                 busy,
  output logic                 valid,
  output logic                 dz,
  output logic [2*WIDTH-1:0]   xyout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     rem_q, dvd_q, dsr_q;
  logic [CntW-1:0]      cnt_q;
  logic                 busy_q, valid_q, dz_q;
  logic [2*WIDTH-1:0]   xy_q;

  logic [WIDTH-1:0]     xmag, ymag;
  logic [WIDTH:0]       shifted, trial;
  logic                 borrow;
  logic [WIDTH-1:0]     rem_nxt;
  logic [WIDTH-1:0]     q_res, r_res;
  logic                 dz_res;

`ifdef FASTDIV_SIGNED_EN
  logic xneg_q, qneg_q;

  always_comb begin
    xmag = xin[WIDTH-1] ? -xin : xin;
    ymag = yin[WIDTH-1] ? -yin : yin;
  end
`else
  always_comb begin
    xmag = xin;
    ymag = yin;
  end
`endif

  // Dividend register shifts out its MSB into the remainder and takes the quotient bit in at LSB.
  always_comb begin
    shifted          = {rem_q, dvd_q[WIDTH-1]};
    {borrow, trial}  = {1'b0, shifted} - {2'b00, dsr_q};
    rem_nxt          = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  end

  always_comb begin
    dz_res = (dsr_q == '0);
    q_res  = dvd_q;
    r_res  = rem_q;
`ifdef FASTDIV_SIGNED_EN
    if (qneg_q) q_res = -dvd_q;
    if (xneg_q) r_res = -rem_q;
    if (dz_res) q_res = '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      xy_q    <= '0;
`ifdef FASTDIV_SIGNED_EN
      xneg_q  <= 1'b0;
      qneg_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (enbl) begin
            dvd_q   <= xmag;
            dsr_q   <= ymag;
            rem_q   <= '0;
            cnt_q   <= CntW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= StRun;
`ifdef FASTDIV_SIGNED_EN
            xneg_q  <= xin[WIDTH-1];
            qneg_q  <= xin[WIDTH-1] ^ yin[WIDTH-1];
`endif
          end
        end
        StRun: begin
          rem_q <= rem_nxt;
          dvd_q <= {dvd_q[WIDTH-2:0], ~borrow};
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          xy_q    <= {r_res, q_res};
          dz_q    <= dz_res;
          valid_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign dz    = dz_q;
  assign xyout = xy_q;

endmodule

// File: tb/tb_fastdiv_seq.sv
// Self-checking bench for fastdiv_seq: WIDTH=8 and WIDTH=16 instances against an arithmetic model.
module tb_fastdiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enbl;
  logic [7:0]  xin, yin;
  logic        busy, valid, dz;
  logic [15:0] xyout;

  logic        enbl16;
  logic [15:0] xin16, yin16;
  logic        busy16, valid16, dz16;
  logic [31:0] xyout16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fastdiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .enbl(enbl), .xin(xin), .yin(yin),
    .busy(busy), .valid(valid), .dz(dz), .xyout(xyout)
  );

  fastdiv_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .enbl(enbl16), .xin(xin16), .yin(yin16),
    .busy(busy16), .valid(valid16), .dz(dz16), .xyout(xyout16)
  );

  // Returns {dz, remainder, quotient}
  function automatic logic [16:0] model8(input logic [7:0] x, input logic [7:0] y);
    int q, r;
`ifdef FASTDIV_SIGNED_EN
    int xs, ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    if (ys == 0) return {1'b1, x, 8'hFF};
    q = xs / ys;
    r = xs % ys;
`else
    if (y == 8'd0) return {1'b1, x, 8'hFF};
    q = int'(x) / int'(y);
    r = int'(x) % int'(y);
`endif
    return {1'b0, r[7:0], q[7:0]};
  endfunction

  function automatic logic [32:0] model16(input logic [15:0] x, input logic [15:0] y);
    int q, r;
`ifdef FASTDIV_SIGNED_EN
    int xs, ys;
    xs = int'($signed(x));
    ys = int'($signed(y));
    if (ys == 0) return {1'b1, x, 16'hFFFF};
    q = xs / ys;
    r = xs % ys;
`else
    if (y == 16'd0) return {1'b1, x, 16'hFFFF};
    q = int'(x) / int'(y);
    r = int'(x) % int'(y);
`endif
    return {1'b0, r[15:0], q[15:0]};
  endfunction

  task automatic do_div8(input logic [7:0] x, input logic [7:0] y,
                         output logic [15:0] xy, output logic d, output int lat);
    @(negedge clk);
    xin = x; yin = y; enbl = 1'b1;
    @(posedge clk); #1;
    enbl = 1'b0;
    lat = 0;
    while (!valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    xy = xyout;
    d  = dz;
  endtask

  task automatic do_div16(input logic [15:0] x, input logic [15:0] y,
                          output logic [31:0] xy, output logic d, output int lat);
    @(negedge clk);
    xin16 = x; yin16 = y; enbl16 = 1'b1;
    @(posedge clk); #1;
    enbl16 = 1'b0;
    lat = 0;
    while (!valid16 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    xy = xyout16;
    d  = dz16;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enbl = 1'b0; enbl16 = 1'b0;
    xin = 8'hA5; yin = 8'h5A; xin16 = 16'h1234; yin16 = 16'h0042;
    #12;
    checks++;
    if ({busy, valid, dz, xyout} !== 19'd0) begin
      errors++;
      $display("FAIL reset8: got %b/%b/%b/%h expected 0/0/0/0000", busy, valid, dz, xyout);
    end
    checks++;
    if ({busy16, valid16, dz16, xyout16} !== 35'd0) begin
      errors++;
      $display("FAIL reset16: got %b/%b/%b/%h expected 0", busy16, valid16, dz16, xyout16);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_directed();
    logic [7:0]  xs [8];
    logic [7:0]  ys [8];
    logic [16:0] exp [8];
    logic [15:0] xy;
    logic d;
    int lat;
`ifdef FASTDIV_SIGNED_EN
    xs = '{8'hF9, 8'h07, 8'h80, 8'hFB, 8'h09, 8'h7F, 8'h80, 8'h01};
    ys = '{8'h02, 8'hFE, 8'hFF, 8'h00, 8'h03, 8'h01, 8'h01, 8'h80};
    exp = '{17'h0FFFD, 17'h001FD, 17'h00080, 17'h1FBFF,
            17'h00003, 17'h0007F, 17'h00080, 17'h00100};
`else
    xs = '{8'd64, 8'd5, 8'd21, 8'd81, 8'd128, 8'd7, 8'd9, 8'd255};
    ys = '{8'd2,  8'd2, 8'd4,  8'd3,  8'd3,   8'd0, 8'd3, 8'd1};
    exp = '{17'h00020, 17'h00102, 17'h00105, 17'h0001B,
            17'h0022A, 17'h107FF, 17'h00003, 17'h000FF};
`endif
    for (int i = 0; i < 8; i++) begin
      do_div8(xs[i], ys[i], xy, d, lat);
      checks++;
      if ({d, xy} !== exp[i]) begin
        errors++;
        $display("FAIL directed[%0d] %h/%h: got dz=%b xy=%h expected %h", i, xs[i], ys[i],
                 d, xy, exp[i]);
      end
      checks++;
      if (lat != 9) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected 9", i, lat);
      end
      @(posedge clk); #1;
      checks++;
      if (valid !== 1'b0) begin
        errors++;
        $display("FAIL valid_pulse[%0d]: got %b expected 0", i, valid);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  x, y;
    logic [15:0] xy;
    logic [16:0] exp;
    logic d;
    int lat;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      exp = model8(x, y);
      do_div8(x, y, xy, d, lat);
      checks++;
      if ({d, xy} !== exp || lat != 9) begin
        errors++;
        $display("FAIL random[%0d] %h/%h: got dz=%b xy=%h lat=%0d expected %h lat=9",
                 i, x, y, d, xy, lat, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  a, b, c, e;
    logic [16:0] exp1, exp2;
    int n, n2, bcnt;
    a = 8'($urandom); b = 8'($urandom_range(1, 255));
    c = 8'($urandom); e = 8'($urandom_range(1, 255));
    exp1 = model8(a, b);
    exp2 = model8(c, e);
    @(negedge clk);
    xin = a; yin = b; enbl = 1'b1;
    @(posedge clk); #1;
    n = 0; bcnt = 0;
    while (!valid && n < 40) begin
      if (busy) bcnt++;
      xin = 8'($urandom); yin = 8'($urandom);
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if ({dz, xyout} !== exp1 || n != 9) begin
      errors++;
      $display("FAIL b2b_first: got dz=%b xy=%h after %0d expected %h after 9", dz, xyout, n, exp1);
    end
    checks++;
    if (bcnt != 8) begin
      errors++;
      $display("FAIL busy_cycles: got %0d expected 8", bcnt);
    end
    xin = c; yin = e;
    n2 = 0;
    do begin
      @(posedge clk); #1;
      n2++;
      xin = 8'($urandom); yin = 8'($urandom);
    end while (!valid && n2 < 40);
    enbl = 1'b0;
    checks++;
    if ({dz, xyout} !== exp2 || n2 != 10) begin
      errors++;
      $display("FAIL b2b_second: got dz=%b xy=%h spacing %0d expected %h spacing 10",
               dz, xyout, n2, exp2);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] xy;
    logic [16:0] exp;
    logic d;
    int lat, nvalid;
    do_div8(8'd200, 8'd7, xy, d, lat);
    @(negedge clk);
    xin = 8'd100; yin = 8'd3; enbl = 1'b1;
    @(posedge clk); #1;
    enbl = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_run: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid, dz, xyout} !== 19'd0) begin
      errors++;
      $display("FAIL mid_run_reset: got %b/%b/%b/%h expected 0/0/0/0000", busy, valid, dz, xyout);
    end
    @(negedge clk); rst_n = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (valid || busy) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL no_valid_after_reset: got %0d active cycles expected 0", nvalid);
    end
    exp = model8(8'd77, 8'd6);
    do_div8(8'd77, 8'd6, xy, d, lat);
    checks++;
    if ({d, xy} !== exp || lat != 9) begin
      errors++;
      $display("FAIL post_reset_div: got dz=%b xy=%h lat=%0d expected %h lat=9", d, xy, lat, exp);
    end
  endtask

  task automatic test_width16();
    logic [15:0] x, y;
    logic [31:0] xy;
    logic [32:0] exp;
    logic d;
    int lat;
    exp = model16(16'd65535, 16'd255);
`ifndef FASTDIV_SIGNED_EN
    checks++;
    if (exp !== {1'b0, 16'd0, 16'd257}) begin
      errors++;
      $display("FAIL model16_ref: got %h expected 0_0000_0101", exp);
    end
`endif
    do_div16(16'd65535, 16'd255, xy, d, lat);
    checks++;
    if ({d, xy} !== exp || lat != 17) begin
      errors++;
      $display("FAIL w16_65535_255: got dz=%b xy=%h lat=%0d expected %h lat=17", d, xy, lat, exp);
    end
    for (int i = 0; i < 8; i++) begin
      x = 16'($urandom);
      y = (i == 3) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 12));
      exp = model16(x, y);
      do_div16(x, y, xy, d, lat);
      checks++;
      if ({d, xy} !== exp || lat != 17) begin
        errors++;
        $display("FAIL w16_random[%0d] %h/%h: got dz=%b xy=%h lat=%0d expected %h lat=17",
                 i, x, y, d, xy, lat, exp);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    test_width16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
